// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: lane width, qNaN constant and FSM states shared by the multiplier arbiter
package fpu_arb_pkg;
  localparam int LANE_W = 32;
  localparam logic [LANE_W-1:0] FP_QNAN = 32'hFFC0_0000;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first set req at or after ptr (wrapping)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = ID_W'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_id = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
    any = |req;
    gnt = any ? NUM_REQ'(1) << gnt_id : '0;
  end
endmodule

// File: rtl/fpu_mul_rr_arbiter.sv
// fpu_mul_rr_arbiter: shares one fpu_multiplier among NUM_REQ lanes, round-robin, one op in flight.
// Define FPU_ARB_TIMEOUT_EN to add a watchdog that answers qNaN and sets a sticky timeout_err.
module fpu_mul_rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*LANE_W-1:0] req_a,
  input  logic [NUM_REQ*LANE_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_stb,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [LANE_W-1:0]         resp_z,
  output logic [NUM_REQ-1:0]        resp_stb,
  input  logic [NUM_REQ-1:0]        resp_ack,
  output logic [LANE_W-1:0]         mul_a,
  output logic [LANE_W-1:0]         mul_b,
  output logic                      mul_a_stb,
  output logic                      mul_b_stb,
  input  logic                      mul_a_ack,
  input  logic                      mul_b_ack,
  input  logic [LANE_W-1:0]         mul_z,
  input  logic                      mul_z_stb,
  output logic                      mul_z_ack,
  output logic                      busy,
  output logic                      timeout_err
);
  if (TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, gnt_id_q, gnt_id_d;
  logic [LANE_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, z_q, z_d;
  logic [LANE_W-1:0]  lane_a [NUM_REQ];
  logic [LANE_W-1:0]  lane_b [NUM_REQ];
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_a[i] = req_a[i*LANE_W +: LANE_W];
    assign lane_b[i] = req_b[i*LANE_W +: LANE_W];
  end
  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_stb),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    z_d      = z_q;
    case (state_q)
      IDLE: if (pick_any) begin
        state_d  = SEND_A;
        gnt_id_d = pick_id;
        op_a_d   = lane_a[pick_id];
        op_b_d   = lane_b[pick_id];
        ptr_d    = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
      end
      SEND_A:  if (mul_a_ack) state_d = SEND_B;
      SEND_B:  if (mul_b_ack) state_d = WAIT_Z;
      WAIT_Z: if (mul_z_stb) begin
        z_d     = mul_z;
        state_d = RESP;
      end
      RESP:    if (resp_ack[gnt_id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FPU_ARB_TIMEOUT_EN
    terr_d = terr_q;
    cnt_d  = (state_q == IDLE) ? '0 : (state_q == RESP) ? cnt_q : cnt_q + 1'b1;
    if (state_q inside {SEND_A, SEND_B, WAIT_Z} && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      z_d     = FP_QNAN;
      terr_d  = 1'b1;
      state_d = RESP;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      z_q      <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      z_q      <= z_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end
  // the ack is gated by rst so nothing is taken during a reset cycle
  assign req_ack   = (state_q == IDLE && !rst) ? pick_gnt : '0;
  assign resp_stb  = (state_q == RESP) ? NUM_REQ'(1) << gnt_id_q : '0;
  assign resp_z    = z_q;
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign mul_a_stb = state_q == SEND_A;
  assign mul_b_stb = state_q == SEND_B;
  assign mul_z_ack = state_q == WAIT_Z;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_fpu_mul_rr_arbiter.sv
// tb_fpu_mul_rr_arbiter: directed tests with a behavioural arbitration model and a multiplier stub
module tb_fpu_mul_rr_arbiter;
  localparam int N = 4;
  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, resp_stb, resp_ack, ack_mask;
  logic [31:0]     resp_z, mul_a, mul_b, mul_z;
  logic            mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
  logic            busy, timeout_err;
  int              errors = 0, checks = 0;
  int              stub_lat = 2;
  bit              stall = 1'b0;
  bit              m_busy = 1'b0, m_terr = 1'b0, to_mode = 1'b0;
  int              m_lane = 0, m_ptr = 0;
  logic [31:0]     m_a = '0, m_b = '0;
  int              glog[$], dlane[$];
  logic [31:0]     dz[$];
  always #5 clk = ~clk;
  fpu_mul_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack), .mul_z(mul_z), .mul_z_stb(mul_z_stb),
    .mul_z_ack(mul_z_ack), .busy(busy), .timeout_err(timeout_err)
  );
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'h7F800000 && b == 32'h00000000) return 32'hFFC00000;
    return a ^ {b[15:0], b[31:16]};
  endfunction
  // multiplier stub: acks operands at once, answers with a one-cycle z pulse after stub_lat cycles
  assign mul_a_ack = mul_a_stb;
  assign mul_b_ack = mul_b_stb;
  logic [31:0] sa, sb;
  bit          pend;
  int          cnt;
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0; mul_z_stb <= 1'b0; mul_z <= '0; cnt <= 0; sa <= '0; sb <= '0;
    end else begin
      mul_z_stb <= 1'b0;
      if (mul_a_stb && mul_a_ack) sa <= mul_a;
      if (mul_b_stb && mul_b_ack) begin
        sb <= mul_b; pend <= !stall; cnt <= stub_lat;
      end else if (pend) begin
        if (cnt == 0) begin
          mul_z_stb <= 1'b1; mul_z <= prod(sa, sb); pend <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int rr_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // one cycle: compare DUT against the model at negedge, advance the model, then let lanes react
  task automatic tick();
    logic [N-1:0] fr, rr, oh, exp_ack;
    logic [31:0]  zexp;
    int           w;
    @(negedge clk);
    w = rr_win(req_stb, m_ptr);
    exp_ack = (!m_busy && !rst && w >= 0) ? N'(1) << w : '0;
    oh = m_busy ? N'(1) << m_lane : '0;
    zexp = to_mode ? 32'hFFC00000 : prod(m_a, m_b);
    if (to_mode && resp_stb != '0) m_terr = 1'b1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("req_ack", 32'(req_ack), 32'(exp_ack));
    chk("stb_when_idle", 32'({mul_a_stb, mul_b_stb, mul_z_ack, resp_stb} & {(N+3){m_busy}}), 32'({mul_a_stb, mul_b_stb, mul_z_ack, resp_stb}));
    chk("resp_lane", 32'(resp_stb & ~oh), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (mul_a_stb) chk("mul_a", mul_a, m_a);
    if (mul_b_stb) chk("mul_b", mul_b, m_b);
    if (resp_stb != '0) chk("resp_z", resp_z, zexp);
    fr = req_stb & req_ack;
    rr = resp_stb & resp_ack;
    for (int i = 0; i < N; i++) begin
      if (fr[i]) glog.push_back(i);
      if (rr[i]) begin dlane.push_back(i); dz.push_back(resp_z); end
    end
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_terr = 1'b0;
    end else if (!m_busy && w >= 0) begin
      m_busy = 1'b1; m_lane = w; m_ptr = (w + 1) % N;
      m_a = req_a[w*32 +: 32]; m_b = req_b[w*32 +: 32];
    end else if (m_busy && resp_stb[m_lane] && resp_ack[m_lane]) m_busy = 1'b0;
    @(posedge clk);
    #1;
    req_stb = req_stb & ~fr;
    resp_ack = resp_stb & ack_mask;
  endtask
  task automatic send(input int lane, input logic [31:0] a, input logic [31:0] b);
    req_a[lane*32 +: 32] = a;
    req_b[lane*32 +: 32] = b;
    req_stb[lane] = 1'b1;
  endtask
  task automatic wait_done(input int n);
    int t = 0;
    while (dlane.size() < n && t < 500) begin tick(); t++; end
    chk("done_count", 32'(dlane.size()), 32'(n));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    glog.delete(); dlane.delete(); dz.delete();
  endtask
  initial begin
    int t;
    rst = 1'b1; req_a = '0; req_b = '0; req_stb = '0; resp_ack = '0; ack_mask = '1;
    do_reset();
    chk("rst_outs", 32'({busy, mul_a_stb, mul_b_stb, mul_z_ack, timeout_err, req_ack, resp_stb}), 32'd0);
    chk("rst_resp_z", resp_z, 32'd0);
    // T1 single request
    send(0, 32'h40000000, 32'h40400000);
    tick();
    chk("t1_grant", 32'(glog.size()), 32'd1);
    chk("t1_ack_pulse", 32'(req_ack), 32'd0);
    wait_done(1);
    chk("t1_lane", 32'(dlane[0]), 32'd0);
    chk("t1_z", dz[0], 32'h40C00000);
    // T2 contention from ptr=0
    do_reset();
    send(0, 32'h3F800000, 32'h40000000);
    send(1, 32'h40000000, 32'h40400000);
    send(2, 32'h3FC00000, 32'h3FC00000);
    send(3, 32'h12345678, 32'h9ABCDEF0);
    wait_done(4);
    chk("t2_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]}, 32'h00010203);
    chk("t2_lane2_z", dz[2], 32'h40100000);
    chk("t2_lane1_z", dz[1], 32'h40C00000);
    // T3 rotation after lane 1
    do_reset();
    send(1, 32'h40000000, 32'h40400000);
    wait_done(1);
    send(0, 32'h11111111, 32'h22222222);
    send(3, 32'h33333333, 32'h44444444);
    wait_done(3);
    chk("t3_order", {8'd0, glog[0][7:0], glog[1][7:0], glog[2][7:0]}, 32'h00010300);
    // T4 response backpressure
    do_reset();
    ack_mask[1] = 1'b0;
    send(1, 32'h40000000, 32'h40400000);
    t = 0;
    while (!resp_stb[1] && t < 100) begin tick(); t++; end
    chk("t4_resp_seen", 32'(resp_stb[1]), 32'd1);
    send(0, 32'h55555555, 32'h66666666);
    repeat (20) tick();
    chk("t4_resp_stb", 32'(resp_stb), 32'h2);
    chk("t4_resp_z", resp_z, 32'h40C00000);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_no_grant", 32'(glog.size()), 32'd1);
    ack_mask[1] = 1'b1;
    wait_done(2);
    chk("t4_order", {glog[0][15:0], glog[1][15:0]}, 32'h00010000);
    // T5 special operands, then reset while waiting for z
    do_reset();
    send(2, 32'h7F800000, 32'h00000000);
    wait_done(1);
    chk("t5_nan", dz[0], 32'hFFC00000);
    stub_lat = 10;
    send(3, 32'h40000000, 32'h40400000);
    t = 0;
    while (!mul_z_ack && t < 100) begin tick(); t++; end
    chk("t5_in_wait_z", 32'(mul_z_ack), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_outs", 32'({busy, mul_a_stb, mul_b_stb, mul_z_ack, timeout_err, req_ack, resp_stb}), 32'd0);
    chk("t5_rst_resp_z", resp_z, 32'd0);
    chk("t5_no_reack", 32'(req_stb), 32'd0);
    stub_lat = 2;
    dlane.delete(); dz.delete();
    send(3, 32'h40000000, 32'h40400000);
    wait_done(1);
    chk("t5_rereq_lane", 32'(dlane[0]), 32'd3);
    chk("t5_rereq_z", dz[0], 32'h40C00000);
`ifdef FPU_ARB_TIMEOUT_EN
    // T6 watchdog with a multiplier that never answers
    do_reset();
    stall = 1'b1;
    to_mode = 1'b1;
    send(0, 32'h40000000, 32'h40400000);
    wait_done(1);
    chk("t6_z", dz[0], 32'hFFC00000);
    chk("t6_terr", 32'(timeout_err), 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
